// File: rtl/fp_pkg.sv
// Shared FP32 field widths, int16 limits and operand types for the FP32 -> int16 converter.
package fp_pkg;

  localparam int unsigned FP32_EXP_W  = 8;
  localparam int unsigned FP32_MANT_W = 23;
  localparam int unsigned FP32_BIAS   = 127;

  localparam logic signed [15:0] INT16_MAX = 16'sh7FFF;
  localparam logic signed [15:0] INT16_MIN = 16'sh8000;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_MANT_W-1:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

endpackage

// File: rtl/fp32_unpack.sv
// Combinational FP32 field split: sign, 24-bit significand with hidden bit, unbiased exponent
// and operand class. Denormals are classed as zero.
module fp32_unpack
  import fp_pkg::*;
(
  input  fp32_t                    fp_i,
  output logic                     sign_o,
  output logic [FP32_MANT_W:0]     mant24_o,
  output logic signed [9:0]        exp_unb_o,
  output fp_class_e                class_o
);

  always_comb begin
    sign_o    = fp_i.sign;
    mant24_o  = {|fp_i.exp, fp_i.mant};
    exp_unb_o = $signed({2'b00, fp_i.exp}) - $signed(10'(FP32_BIAS));
    class_o   = FP_NORM;
    if (fp_i.exp == '0) begin
      class_o = FP_ZERO;
    end else if (&fp_i.exp) begin
      class_o = (fp_i.mant == '0) ? FP_INF : FP_NAN;
    end
  end

endmodule

// File: rtl/fp32_to_int16_converter.sv
// Two-stage FP32 -> signed Q(15-FRAC_BITS).FRAC_BITS converter with valid/ready on both sides.
// Build option FP2I_ROUND_EN: round half away from zero; otherwise truncate toward zero.
module fp32_to_int16_converter
  import fp_pkg::*;
#(
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_sat,
  output logic        out_nan
);

`ifdef FP2I_ROUND_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

  fp32_t             in_fp;
  logic              u_sign;
  logic [23:0]       u_mant;
  logic signed [9:0] u_exp_unb;
  fp_class_e         u_class;

  assign in_fp = fp32_t'(in_data);

  fp32_unpack u_unpack (
    .fp_i      (in_fp),
    .sign_o    (u_sign),
    .mant24_o  (u_mant),
    .exp_unb_o (u_exp_unb),
    .class_o   (u_class)
  );

  logic s1_en, s2_en;

  logic              s1_valid_d, s1_valid_q;
  logic              s1_sign_d, s1_sign_q;
  logic [23:0]       s1_mant_d, s1_mant_q;
  logic signed [9:0] s1_shift_d, s1_shift_q;
  fp_class_e         s1_class_d, s1_class_q;

  logic        out_valid_d, out_valid_q;
  logic [15:0] out_data_d, out_data_q;
  logic        out_sat_d, out_sat_q;
  logic        out_nan_d, out_nan_q;

  // No skid buffer: upstream sees back-pressure in the same cycle.
  always_comb begin
    s2_en    = !out_valid_q || out_ready;
    s1_en    = !s1_valid_q || s2_en;
    in_ready = s1_en;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mant_d  = s1_mant_q;
    s1_shift_d = s1_shift_q;
    s1_class_d = s1_class_q;
    if (s1_en) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d  = u_sign;
        s1_mant_d  = u_mant;
        // Binary point of mant24 sits 23 bits up; move it to FRAC_BITS.
        s1_shift_d = u_exp_unb + $signed(10'(FRAC_BITS)) - 10'sd23;
        s1_class_d = u_class;
      end
    end
  end

  logic [9:0]  rshift;
  logic [24:0] ext;
  logic [40:0] mag;
  logic        ovf;
  logic        mag_sat;
  logic [15:0] mag16;
  logic [15:0] conv;
  logic [15:0] res_data;
  logic        res_sat;
  logic        res_nan;

  always_comb begin
    rshift = 10'(-s1_shift_q);
    ext    = '0;
    mag    = '0;
    ovf    = 1'b0;
    if (!s1_shift_q[9]) begin
      // Any left shift past 17 exceeds the 41-bit window and is far beyond int16 anyway.
      if (s1_shift_q > 10'sd17) begin
        ovf = 1'b1;
      end else begin
        mag = {17'b0, s1_mant_q} << s1_shift_q[4:0];
      end
    end else if (rshift < 10'd25) begin
      // Extra LSB below the significand lands on the guard bit after the shift.
      ext = {s1_mant_q, 1'b0} >> rshift;
      mag = {17'b0, ext[24:1]} + 41'(RoundEn & ext[0]);
    end

    mag_sat = ovf || (s1_sign_q ? (mag > 41'd32768) : (mag > 41'd32767));
    mag16   = mag[15:0];
    conv    = s1_sign_q ? (16'd0 - mag16) : mag16;

    res_data = '0;
    res_sat  = 1'b0;
    res_nan  = 1'b0;
    unique case (s1_class_q)
      FP_NAN: begin
        res_nan = 1'b1;
      end
      FP_INF: begin
        res_data = s1_sign_q ? INT16_MIN : INT16_MAX;
        res_sat  = 1'b1;
      end
      FP_ZERO: begin
        res_data = '0;
      end
      default: begin
        res_sat  = mag_sat;
        res_data = mag_sat ? (s1_sign_q ? INT16_MIN : INT16_MAX) : conv;
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_nan_d   = out_nan_q;
    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = res_data;
        out_sat_d  = res_sat;
        out_nan_d  = res_nan;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mant_q   <= '0;
      s1_shift_q  <= '0;
      s1_class_q  <= FP_ZERO;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_nan_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_mant_q   <= s1_mant_d;
      s1_shift_q  <= s1_shift_d;
      s1_class_q  <= s1_class_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_nan_q   <= out_nan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_nan   = out_nan_q;

endmodule

// File: tb/tb_fp32_to_int16_converter.sv
// Self-checking bench for fp32_to_int16_converter: directed corner words plus randomized
// streams scored against an arithmetic reference model.
module tb_fp32_to_int16_converter;

  localparam int unsigned FRAC_BITS = 8;
`ifdef FP2I_ROUND_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_sat;
  logic        out_nan;

  int n_checks = 0;
  int n_fail   = 0;

  logic [17:0] pend[$];
  logic        hold_q = 1'b0;
  logic [17:0] held = '0;
  logic        last_acc = 1'b0;
  logic        last_ovalid = 1'b0;

  fp32_to_int16_converter #(
    .FRAC_BITS (FRAC_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_nan   (out_nan)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Value = mant24 * 2^(exp-150) * 2^FRAC_BITS, evaluated with integer arithmetic.
  function automatic logic [17:0] ref_conv(input logic [31:0] w);
    longint    mant, mag, dv, q, r, val;
    int        p, k;
    logic      s, sat;
    logic [7:0] e;
    s = w[31];
    e = w[30:23];
    if (e == 8'hFF) return (w[22:0] != 0) ? {16'h0000, 2'b01} : {(s ? 16'h8000 : 16'h7FFF), 2'b10};
    if (e == 8'h00) return '0;
    mant = 64'd8388608 + longint'(w[22:0]);
    p = int'(e) - 150 + int'(FRAC_BITS);
    if (p >= 0) begin
      mag = (p >= 20) ? (64'd1 << 40) : mant * (64'd1 << p);
    end else begin
      k = -p;
      if (k >= 40) begin
        mag = 0;
      end else begin
        dv = 64'd1 << k;
        q  = mant / dv;
        r  = mant % dv;
        if (RoundEn && (2 * r >= dv)) q = q + 1;
        mag = q;
      end
    end
    sat = s ? (mag > 32768) : (mag > 32767);
    if (sat) val = s ? -32768 : 32767;
    else     val = s ? -mag : mag;
    return {val[15:0], sat, 1'b0};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [7:0] e;
    logic [22:0] m;
    int r;
    r = $urandom_range(0, 15);
    m = 23'($urandom);
    if (r == 0)      e = 8'h00;
    else if (r == 1) e = 8'hFF;
    else if (r == 2) begin e = 8'hFF; m = '0; end
    else             e = 8'($urandom_range(100, 145));
    return {1'($urandom), e, m};
  endfunction

  // One clock: drive at negedge, sample just after, score the handshakes due at the next posedge.
  task automatic cycle(input logic iv, input logic [31:0] id, input logic [17:0] expv,
                       input logic ordy);
    logic [17:0] obs;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    obs = {out_data, out_sat, out_nan};
    check_eq("in_ready", 32'(in_ready), 32'(!(pend.size() == 2 && !ordy)));
    if (hold_q) begin
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_eq("stall_data", 32'(obs), 32'(held));
    end
    if (pend.size() == 0) check_eq("idle_valid", 32'(out_valid), 32'd0);
    else if (out_valid && ordy) check_eq("out_word", 32'(obs), 32'(pend.pop_front()));
    last_acc = iv && in_ready;
    if (last_acc) pend.push_back(expv);
    hold_q      = out_valid && !ordy;
    held        = obs;
    last_ovalid = out_valid;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && pend.size() != 0; i++) cycle(1'b0, '0, '0, 1'b1);
    check_eq("drain", 32'(pend.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pend.delete();
    hold_q = 1'b0;
  endtask

  logic [31:0] dw[12];
  logic [17:0] de[12];
  logic [31:0] sw[8];

  initial begin
    dw = '{32'hC0200000, 32'h43480000, 32'hC3000000, 32'hFF800000, 32'h7F800000, 32'h7FC00000,
           32'h00400000, 32'h80000000, 32'h3BC00000, 32'hBBC00000, 32'h3F000000, 32'h43000000};
    de = '{{16'hFD80, 2'b00}, {16'h7FFF, 2'b10}, {16'h8000, 2'b00}, {16'h8000, 2'b10},
           {16'h7FFF, 2'b10}, {16'h0000, 2'b01}, {16'h0000, 2'b00}, {16'h0000, 2'b00},
           {16'h0001, 2'b00}, {16'hFFFF, 2'b00}, {16'h0080, 2'b00}, {16'h7FFF, 2'b10}};
    if (RoundEn) begin
      de[8] = {16'h0002, 2'b00};
      de[9] = {16'hFFFE, 2'b00};
    end

    do_reset();
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_out_sat", 32'(out_sat), 32'd0);
    check_eq("rst_out_nan", 32'(out_nan), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // 1.0 with latency check
    cycle(1'b1, 32'h3F800000, {16'h0100, 2'b00}, 1'b1);
    check_eq("accept_1p0", 32'(last_acc), 32'd1);
    cycle(1'b0, '0, '0, 1'b1);
    check_eq("lat_s1", 32'(last_ovalid), 32'd0);
    cycle(1'b0, '0, '0, 1'b1);
    check_eq("lat_s2", 32'(last_ovalid), 32'd1);
    drain();

    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, dw[i], de[i], 1'b1);
      drain();
    end

    // 8 back-to-back words with random back-pressure
    for (int i = 0; i < 8; i++) sw[i] = rand_word();
    begin
      int idx = 0;
      for (int c = 0; c < 200 && idx < 8; c++) begin
        cycle(1'b1, sw[idx], ref_conv(sw[idx]), 1'($urandom));
        if (last_acc) idx++;
      end
      check_eq("stream_sent", 32'(idx), 32'd8);
    end
    drain();

    // longer random traffic on both sides
    for (int c = 0; c < 400; c++) begin
      logic [31:0] w;
      w = rand_word();
      cycle(1'($urandom_range(0, 3) != 0), w, ref_conv(w), 1'($urandom));
    end
    drain();

    // fill the pipe, then reset mid-flight
    cycle(1'b1, 32'h3F800000, {16'h0100, 2'b00}, 1'b0);
    cycle(1'b1, 32'h40000000, {16'h0200, 2'b00}, 1'b0);
    cycle(1'b1, 32'h40400000, {16'h0300, 2'b00}, 1'b0);
    check_eq("full_blocked", 32'(last_acc), 32'd0);
    do_reset();
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
